// File: rtl/tdp_ram_cfg.sv
// ---------------------------------------------------------------------------
// tdp_ram_cfg
// Single-clock true dual-port RAM with per-lane write enables, a selectable
// same-port read-during-write behaviour, an optional output pipeline register,
// cross-port collision arbitration and a post-reset memory-clear sequencer.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset (released synchronously upstream)
//   busy       : high while the clear sequencer owns the memory
//   ena/enb    : port access enable
//   wea/web    : per-lane write enables (all zero = read access)
//   addra/b    : word address
//   dina/b     : write data
//   douta/b    : read data, holds its value between results
//   douta/b_vld: one-cycle pulse marking a new read result
//   collision  : pulse aligned with the read result of a same-address access
//                where at least one port wrote
// ---------------------------------------------------------------------------
module tdp_ram_cfg #(
    parameter int AW       = 4,
    parameter int DW       = 8,
    parameter int LW       = 4,
    parameter int MODE     = 0,
    parameter int OUT_REG  = 0,
    parameter int INIT_CLR = 1,
    localparam int NL      = DW / LW
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          busy,
    input  logic          ena,
    input  logic [NL-1:0] wea,
    input  logic [AW-1:0] addra,
    input  logic [DW-1:0] dina,
    output logic [DW-1:0] douta,
    output logic          douta_vld,
    input  logic          enb,
    input  logic [NL-1:0] web,
    input  logic [AW-1:0] addrb,
    input  logic [DW-1:0] dinb,
    output logic [DW-1:0] doutb,
    output logic          doutb_vld,
    output logic          collision
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_READY} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic [DW-1:0] mem [DEPTH];

    // -------------------------------------------------------------------
    // Clear sequencer
    // -------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                state_d = (INIT_CLR != 0) ? ST_CLEAR : ST_READY;
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (INIT_CLR != 0) ? ST_CLEAR : ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == ST_CLEAR);

    // -------------------------------------------------------------------
    // Port decode
    // -------------------------------------------------------------------
    logic          acc_a, acc_b;
    logic [NL-1:0] wr_a, wr_b;
    logic [DW-1:0] old_a, old_b, new_a, new_b;
    logic [DW-1:0] rdat_a, rdat_b;
    logic          upd_a, upd_b, coll;

    always_comb begin
        acc_a = ena & ~busy;
        acc_b = enb & ~busy;
        wr_a  = acc_a ? wea : '0;
        wr_b  = acc_b ? web : '0;
        // The array is written at the clock edge, so these are the pre-write
        // words: a reader on the other port always sees the old contents.
        old_a = mem[addra];
        old_b = mem[addrb];
        new_a = old_a;
        new_b = old_b;
        for (int i = 0; i < NL; i++) begin
            if (wr_a[i]) new_a[i*LW +: LW] = dina[i*LW +: LW];
            if (wr_b[i]) new_b[i*LW +: LW] = dinb[i*LW +: LW];
        end
        rdat_a = (MODE == 1) ? new_a : old_a;
        rdat_b = (MODE == 1) ? new_b : old_b;
        // No-change mode suppresses the result of any write access.
        upd_a  = acc_a && !((MODE == 2) && (|wr_a));
        upd_b  = acc_b && !((MODE == 2) && (|wr_b));
        coll   = acc_a && acc_b && (addra == addrb) && ((|wr_a) || (|wr_b));
    end

    // -------------------------------------------------------------------
    // Memory array (contents are never reset). Port A is written after
    // port B so that A wins on lanes both ports write.
    // -------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt_q] <= '0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (wr_b[i]) mem[addrb][i*LW +: LW] <= dinb[i*LW +: LW];
                if (wr_a[i]) mem[addra][i*LW +: LW] <= dina[i*LW +: LW];
            end
        end
    end

    // -------------------------------------------------------------------
    // First read stage
    // -------------------------------------------------------------------
    logic [DW-1:0] dat1_a_q, dat1_a_d, dat1_b_q, dat1_b_d;
    logic          vld1_a_q, vld1_a_d, vld1_b_q, vld1_b_d;
    logic          coll1_q, coll1_d;

    always_comb begin
        dat1_a_d = upd_a ? rdat_a : dat1_a_q;
        dat1_b_d = upd_b ? rdat_b : dat1_b_q;
        vld1_a_d = upd_a;
        vld1_b_d = upd_b;
        coll1_d  = coll;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat1_a_q <= '0;
            dat1_b_q <= '0;
            vld1_a_q <= 1'b0;
            vld1_b_q <= 1'b0;
            coll1_q  <= 1'b0;
        end else begin
            dat1_a_q <= dat1_a_d;
            dat1_b_q <= dat1_b_d;
            vld1_a_q <= vld1_a_d;
            vld1_b_q <= vld1_b_d;
            coll1_q  <= coll1_d;
        end
    end

    // -------------------------------------------------------------------
    // Optional output register
    // -------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DW-1:0] dat2_a_q, dat2_a_d, dat2_b_q, dat2_b_d;
            logic          vld2_a_q, vld2_a_d, vld2_b_q, vld2_b_d;
            logic          coll2_q, coll2_d;

            always_comb begin
                dat2_a_d = vld1_a_q ? dat1_a_q : dat2_a_q;
                dat2_b_d = vld1_b_q ? dat1_b_q : dat2_b_q;
                vld2_a_d = vld1_a_q;
                vld2_b_d = vld1_b_q;
                coll2_d  = coll1_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dat2_a_q <= '0;
                    dat2_b_q <= '0;
                    vld2_a_q <= 1'b0;
                    vld2_b_q <= 1'b0;
                    coll2_q  <= 1'b0;
                end else begin
                    dat2_a_q <= dat2_a_d;
                    dat2_b_q <= dat2_b_d;
                    vld2_a_q <= vld2_a_d;
                    vld2_b_q <= vld2_b_d;
                    coll2_q  <= coll2_d;
                end
            end

            assign douta     = dat2_a_q;
            assign doutb     = dat2_b_q;
            assign douta_vld = vld2_a_q;
            assign doutb_vld = vld2_b_q;
            assign collision = coll2_q;
        end else begin : g_no_out_reg
            assign douta     = dat1_a_q;
            assign doutb     = dat1_b_q;
            assign douta_vld = vld1_a_q;
            assign doutb_vld = vld1_b_q;
            assign collision = coll1_q;
        end
    endgenerate

endmodule
